// File: rtl/button_irq_servicer_if.sv
// Avalon-MM master/slave signal bundle between the button servicer and the PIO interconnect.
interface button_irq_servicer_if;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  modport master (
    output avm_address, avm_read, avm_write, avm_writedata,
    input  avm_readdata, avm_readdatavalid, avm_waitrequest
  );

  modport slave (
    input  avm_address, avm_read, avm_write, avm_writedata,
    output avm_readdata, avm_readdatavalid, avm_waitrequest
  );
endinterface

// File: rtl/button_irq_servicer.sv
// Services the button PIO interrupt over Avalon-MM and queues {edges, level} events in a
// first-word-fall-through FIFO; also keeps the slave's irq mask in step with cfg_mask.
module button_irq_servicer #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [1:0]  ADDR_DATA = 2'd0,
  parameter logic [1:0]  ADDR_MASK = 2'd2,
  parameter logic [1:0]  ADDR_EDGE = 2'd3
) (
  input  logic                         clk,
  input  logic                         reset_n,
  button_irq_servicer_if.master        avm,
  input  logic                         irq_in,
  input  logic [3:0]                   cfg_mask,
  output logic                         evt_valid,
  input  logic                         evt_ready,
  output logic [3:0]                   evt_edges,
  output logic [3:0]                   evt_level,
  output logic [7:0]                   drop_count
);
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

  typedef enum logic [2:0] {
    StWrMask, StIdle, StRdEdge, StWtEdge, StWrClr, StRdLvl, StWtLvl, StPush
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  addr_q, addr_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [3:0]  wdata_q, wdata_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [3:0]  edges_q, edges_d;
  logic [3:0]  level_q, level_d;
  logic        push_req;
  logic        cmd_done;

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic [7:0]      drop_q;
  logic            fifo_full, push, drop, pop;
  logic [7:0]      head;
  logic            unused_rdata;

  assign cmd_done     = (read_q | write_q) & ~avm.avm_waitrequest;
  assign unused_rdata = ^avm.avm_readdata[31:4];

  // Strobes are registered; the next command is loaded in the same cycle the
  // previous one completes so back-to-back commands lose no cycle.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    read_d   = read_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    shadow_d = shadow_q;
    edges_d  = edges_q;
    level_d  = level_q;
    push_req = 1'b0;
    unique case (state_q)
      StWrMask: begin
        if (!write_q) begin
          write_d = 1'b1;
          addr_d  = ADDR_MASK;
          wdata_d = cfg_mask;
        end else if (cmd_done) begin
          write_d  = 1'b0;
          shadow_d = wdata_q;
          state_d  = StIdle;
        end
      end
      StIdle: begin
        if (cfg_mask != shadow_q) begin
          state_d = StWrMask;
          write_d = 1'b1;
          addr_d  = ADDR_MASK;
          wdata_d = cfg_mask;
        end else if (irq_in) begin
          state_d = StRdEdge;
          read_d  = 1'b1;
          addr_d  = ADDR_EDGE;
        end
      end
      StRdEdge: begin
        if (cmd_done) begin
          read_d  = 1'b0;
          state_d = StWtEdge;
        end
      end
      StWtEdge: begin
        if (avm.avm_readdatavalid) begin
          edges_d = avm.avm_readdata[3:0];
          if (avm.avm_readdata[3:0] == 4'h0) begin
            state_d = StIdle;
          end else begin
            state_d = StWrClr;
            write_d = 1'b1;
            addr_d  = ADDR_EDGE;
            wdata_d = 4'h0;
          end
        end
      end
      StWrClr: begin
        if (cmd_done) begin
          write_d = 1'b0;
          state_d = StRdLvl;
          read_d  = 1'b1;
          addr_d  = ADDR_DATA;
        end
      end
      StRdLvl: begin
        if (cmd_done) begin
          read_d  = 1'b0;
          state_d = StWtLvl;
        end
      end
      StWtLvl: begin
        if (avm.avm_readdatavalid) begin
          level_d = avm.avm_readdata[3:0];
          state_d = StPush;
        end
      end
      StPush: begin
        push_req = 1'b1;
        state_d  = StIdle;
      end
    endcase
    if (!read_d && !write_d) begin
      addr_d  = 2'd0;
      wdata_d = 4'h0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StWrMask;
      addr_q   <= 2'd0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      wdata_q  <= 4'h0;
      shadow_q <= 4'h0;
      edges_q  <= 4'h0;
      level_q  <= 4'h0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      read_q   <= read_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      edges_q  <= edges_d;
      level_q  <= level_d;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_read      = read_q;
  assign avm.avm_write     = write_q;
  assign avm.avm_writedata = {28'd0, wdata_q};

  // Push/drop decided on the pre-pop occupancy, so a full FIFO drops even if popped now.
  assign fifo_full = (count_q == FullCnt);
  assign push      = push_req & ~fifo_full;
  assign drop      = push_req & fifo_full;
  assign evt_valid = (count_q != '0);
  assign pop       = evt_valid & evt_ready;
  assign head      = mem_q[rptr_q];
  assign evt_edges = evt_valid ? head[7:4] : 4'h0;
  assign evt_level = evt_valid ? head[3:0] : 4'h0;
  assign drop_count = drop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      drop_q  <= 8'd0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_q + CntW'(push) - CntW'(pop);
      if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {edges_q, level_q};
  end
endmodule

// File: doc/button_irq_servicer.md
Name: button_irq_servicer

Overview:
- Avalon-MM master that services the 4-bit button PIO slave: on PIO interrupt, reads edge-capture, clears it, snapshots pin levels, and queues an event.
- Programs the slave's irq mask after reset and whenever the mask configuration changes.
- Sits between the PIO slave (through the interconnect) and a hardware consumer such as the HDMI overlay control, so no CPU interrupt handler is needed.

Parameters:
- DEPTH, 4: event FIFO depth in entries; power of two, 2..16.
- ADDR_DATA, 0: slave word address of the data/level register.
- ADDR_MASK, 2: slave word address of the irq-mask register.
- ADDR_EDGE, 3: slave word address of the edge-capture register.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset.
- avm_address  out  2  slave word address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_readdata  in  32  read data.
- avm_readdatavalid  in  1  read data valid strobe.
- avm_waitrequest  in  1  interconnect stall.
- irq_in  in  1  PIO interrupt, level.
- cfg_mask  in  4  desired irq mask.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts the head event.
- evt_edges  out  4  captured falling-edge bits of the head event.
- evt_level  out  4  pin levels sampled after the clear.
- drop_count  out  8  events dropped on FIFO full; saturates at 255.

Behaviour:
- Reset is asynchronous and active-low on reset_n; clock is clk.
- Reset values: all avm_* outputs 0, evt_valid 0, evt_edges/evt_level 0, drop_count 0, FIFO empty, mask shadow 0, FSM in WR_MASK.
- Command hold rule: a command (read or write) holds address, data and strobe stable while avm_waitrequest=1. It completes on the first clk edge with waitrequest=0, and the strobe deasserts on the next cycle.
- Only one read is outstanding at a time; avm_read is never asserted while waiting for readdatavalid.
- FSM states and transitions:
  - WR_MASK: write cfg_mask, zero-extended, to ADDR_MASK. Shadow mask <= cfg_mask on completion. Then IDLE.
  - IDLE: if cfg_mask != shadow, go to WR_MASK. Else if irq_in=1, go to RD_EDGE. The mask change has priority when both occur together.
  - RD_EDGE: issue read of ADDR_EDGE, then go to WT_EDGE.
  - WT_EDGE: on readdatavalid, latch edges <= readdata[3:0]. If edges==0 (spurious), go to IDLE with no write and no push. Else go to WR_CLR.
  - WR_CLR: write 0 to ADDR_EDGE; the slave clears all bits on any write. Then RD_LVL.
  - RD_LVL: issue read of ADDR_DATA, then go to WT_LVL.
  - WT_LVL: on readdatavalid, latch level <= readdata[3:0], then go to PUSH.
  - PUSH: takes one cycle. If FIFO not full, enqueue {edges, level}. Else drop and increment drop_count, saturating. Then IDLE.
- The clear write is issued on the cycle after edge data returns, to minimise the window in which a new edge can be lost. Edges the slave detects during the clear cycle are lost by design.
- Minimum service latency is 7 clk cycles, with zero waitrequest and 1-cycle read latency, from IDLE seeing irq_in to the event appearing at FIFO output.
- irq_in staying high after the clear (a new edge) simply re-enters RD_EDGE from IDLE.
- FIFO behaviour:
  - First-word-fall-through: evt_valid=1 whenever the FIFO is non-empty, and evt_* show the head entry.
  - Pop on evt_valid and evt_ready.
  - Push and pop in the same cycle while full is not possible, because the push decision is made on the pre-pop state. A push into a full FIFO is dropped even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH; a count register of log2(DEPTH)+1 bits distinguishes full from empty.
- cfg_mask changes during a service sequence are deferred until IDLE.
- reset_n asserted mid-sequence aborts the bus command immediately. The FSM restarts in WR_MASK, and FIFO contents and drop_count are lost.
- avm_writedata[31:4] is always 0.

Test Plan:
- Release reset with cfg_mask=4'b1111 -> exactly one write, addr 2 with data 0x0000000F; then idle with no bus activity.
- irq_in=1 with edge register reading 0x5 and level reading 0xA -> sequence: read 3, write 3 data 0, read 0. Event edges=0x5, level=0xA appears 7 cycles after irq_in; evt_valid held until evt_ready.
- Spurious irq with edge read returning 0 -> no clear write, no event, FSM returns to IDLE.
- avm_waitrequest held high for 3 cycles on each command -> address, data and strobes stay stable throughout; event data is still correct.
- Hold evt_ready=0 and deliver 6 interrupts with DEPTH=4 -> 4 events queued in order, drop_count=2. Then evt_ready=1 drains them in order.
- Change cfg_mask from 0xF to 0x3 while a service is in WT_LVL -> service completes first, then a write to addr 2 with data 0x3 follows.
